// File: rtl/round_seq_core.sv
// Iterative round engine: ROUNDS x (key XOR, S-box, linear mix), key whitening, one-deep result buffer.
// Latency: accept at edge 0 -> out_valid after edge ROUNDS+1; one block per ROUNDS+2 cycles.
// Backpressure: a full buffer with out_ready low stalls the engine in FIN; in_ready stays low until the result is written.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready input block handshake; in_data and lin_bypass_last are taken on accept
//   rk_idx/rk_data    round-key lookup; rk_data must answer rk_idx combinationally
//   out_valid/ready   result handshake; out_data is held while out_valid=1 and out_ready=0
//   busy              engine is running a block or waiting to write its result
module round_seq_core #(
  parameter  int LANES  = 16,
  parameter  int ROUNDS = 10,
  parameter  int ROT    = 1,
  localparam int RKW    = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               lin_bypass_last,
  output logic [RKW-1:0]     rk_idx,
  input  logic [8*LANES-1:0] rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int W = 8 * LANES;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [RKW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   st_q, st_d;
  logic           byp_q, byp_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;

  logic [W-1:0]   rnd_sub;
  logic [W-1:0]   rnd_lin;
  logic           last_round;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [W-1:0] sub_layer(input logic [W-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 2 * LANES; i++) begin
      r[4*i +: 4] = sbox4(s[4*i +: 4]);
    end
    return r;
  endfunction

  // Lanes are first rotated by ROT, then each output byte folds in its two
  // upper neighbours (the second one rotated left by one bit).
  function automatic logic [W-1:0] lin_layer(input logic [W-1:0] s);
    logic [7:0]   t [LANES];
    logic [7:0]   c;
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      t[i] = s[8*((i + ROT) % LANES) +: 8];
    end
    for (int i = 0; i < LANES; i++) begin
      c = t[(i + 2) % LANES];
      r[8*i +: 8] = t[i] ^ t[(i + 1) % LANES] ^ {c[6:0], c[7]};
    end
    return r;
  endfunction

  assign rnd_sub    = sub_layer(st_q ^ rk_data);
  assign rnd_lin    = lin_layer(rnd_sub);
  assign last_round = (cnt_q == RKW'(ROUNDS - 1));

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    byp_d       = byp_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rk_idx      = '0;
    in_ready    = 1'b0;

    // A drain empties the buffer unless FIN refills it below in the same cycle.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d  = in_data;
          byp_d = lin_bypass_last;
          cnt_d = '0;
          fsm_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_idx = cnt_q;
        st_d   = (last_round && byp_q) ? rnd_sub : rnd_lin;
        cnt_d  = cnt_q + RKW'(1);
        if (last_round) begin
          fsm_d = ST_FIN;
        end
      end
      ST_FIN: begin
        rk_idx = RKW'(ROUNDS);
        if (!out_valid_q || out_ready) begin
          out_data_d  = st_q ^ rk_data;
          out_valid_d = 1'b1;
          fsm_d       = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      byp_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      byp_q       <= byp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (fsm_q != ST_IDLE);

endmodule
